// File: rtl/branch_sequencer_if.sv
// Decoder <-> branch sequencer handshake: issue fields in, PC-load/stack status out.
interface branch_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 8
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic              start;
  logic [1:0]        op;
  logic              cond_en;
  logic              fl;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next;
  logic              busy;
  logic              done;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_value;
  logic              taken;
  logic              stack_ovf;
  logic              stack_unf;
  logic [SP_W-1:0]   sp;

  modport master (
    output start, op, cond_en, fl, target, pc_next,
    input  busy, done, pc_load, pc_value, taken, stack_ovf, stack_unf, sp
  );

  modport slave (
    input  start, op, cond_en, fl, target, pc_next,
    output busy, done, pc_load, pc_value, taken, stack_ovf, stack_unf, sp
  );
endinterface

// File: rtl/branch_sequencer.sv
// JMP/CALL/RET/SKIP sequencer with a hardware return-address stack.
// BRSEQ_ERR_TRAP_EN: stack overflow/underflow loads TRAP_VEC instead of being a no-op.
module branch_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(8'hF0)
) (
  input  logic               clk,
  input  logic               rst,
  branch_sequencer_if.slave  bus
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EVAL = 3'd1,
    ST_PUSH = 3'd2,
    ST_POP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_JMP  = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_SKIP = 2'b11
  } op_t;

  state_t            state_r, state_nxt_s;
  op_t               op_r;
  logic              cond_en_r;
  logic [ADDR_W-1:0] target_r;
  logic [ADDR_W-1:0] pc_next_r;
  logic [SP_W-1:0]   sp_r;
  logic [ADDR_W-1:0] pc_value_r;
  logic              taken_r;
  logic              ovf_r;
  logic              unf_r;
  logic [ADDR_W-1:0] mem_r [STACK_DEPTH];

  logic              cond_hit_s;
  logic              full_s;
  logic              empty_s;
  logic              err_s;
  logic [IDX_W-1:0]  push_idx_s;
  logic [IDX_W-1:0]  pop_idx_s;

  assign cond_hit_s = ~cond_en_r | bus.fl;
  assign full_s     = (sp_r == SP_FULL);
  assign empty_s    = (sp_r == SP_W'(0));
  assign err_s      = cond_hit_s & (((op_r == OP_CALL) & full_s) | ((op_r == OP_RET) & empty_s));
  assign push_idx_s = IDX_W'(sp_r);
  assign pop_idx_s  = IDX_W'(sp_r - SP_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; fl only matters in EVAL
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_EVAL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (!cond_hit_s || err_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          case (op_r)
            OP_CALL: state_nxt_s = ST_PUSH;
            OP_RET:  state_nxt_s = ST_POP;
            default: state_nxt_s = ST_DONE;
          endcase
        end
      end
      ST_PUSH: state_nxt_s = ST_DONE;
      ST_POP:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Instruction latch, decision, stack pointer and PC value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= OP_JMP;
      cond_en_r  <= 1'b0;
      target_r   <= '0;
      pc_next_r  <= '0;
      sp_r       <= '0;
      pc_value_r <= '0;
      taken_r    <= 1'b0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            op_r      <= op_t'(bus.op);
            cond_en_r <= bus.cond_en;
            target_r  <= bus.target;
            pc_next_r <= bus.pc_next;
          end
        end
        ST_EVAL: begin
`ifdef BRSEQ_ERR_TRAP_EN
          taken_r <= cond_hit_s;
`else
          taken_r <= cond_hit_s & ~err_s;
`endif
          // pc_value is only meaningful with pc_load, so the trap vector is loaded unconditionally on error
          if (err_s) begin
            pc_value_r <= TRAP_VEC;
            if (op_r == OP_CALL) begin
              ovf_r <= 1'b1;
            end else begin
              unf_r <= 1'b1;
            end
          end else if (op_r == OP_JMP) begin
            pc_value_r <= target_r;
          end else if (op_r == OP_SKIP) begin
            pc_value_r <= pc_next_r + ADDR_W'(1);
          end
        end
        ST_PUSH: begin
          sp_r       <= sp_r + SP_W'(1);
          pc_value_r <= target_r;
        end
        ST_POP: begin
          sp_r       <= sp_r - SP_W'(1);
          pc_value_r <= mem_r[pop_idx_s];
        end
        default: begin
        end
      endcase
    end
  end

  // Return-address RAM, written only on leaving PUSH so a reset during PUSH suppresses the write
  always_ff @(posedge clk) begin
    if (state_r == ST_PUSH) begin
      mem_r[push_idx_s] <= pc_next_r;
    end
  end

  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.done      = (state_r == ST_DONE);
  assign bus.pc_load   = (state_r == ST_DONE) & taken_r;
  assign bus.pc_value  = pc_value_r;
  assign bus.taken     = taken_r;
  assign bus.stack_ovf = ovf_r;
  assign bus.stack_unf = unf_r;
  assign bus.sp        = sp_r;
endmodule
